// File: rtl/reg_cmd_initiator.sv
// reg_cmd_initiator: serialises register read/write requests into ASCII UDP command frames and collects read replies.
// Optional: define REG_CMD_WRITE_VERIFY_EN to follow every write with an automatic readback of the same register.
module reg_cmd_initiator #(
    parameter int REGS_NUM       = 4,
    parameter int REG_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cmd_write,
    input  logic [2:0]           i_cmd_reg,
    input  logic [REG_WIDTH-1:0] i_cmd_wdata,
    output logic [7:0]           o_tx_udp_payload_axis_tdata,
    output logic                 o_tx_udp_payload_axis_tvalid,
    output logic                 o_tx_udp_payload_axis_tlast,
    input  logic                 i_tx_udp_payload_axis_tready,
    input  logic [7:0]           i_rx_udp_payload_axis_tdata,
    input  logic                 i_rx_udp_payload_axis_tvalid,
    input  logic                 i_rx_udp_payload_axis_tlast,
    output logic                 o_rx_udp_payload_axis_tready,
    output logic                 o_rsp_valid,
    output logic [REG_WIDTH-1:0] o_rsp_rdata,
    output logic                 o_rsp_error,
    output logic                 o_busy
);
    localparam int N  = REG_WIDTH / 8;
    localparam int PW = $clog2(N + 3);
    localparam int RW = $clog2(N + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0] REG_LIM = 4'(REGS_NUM);
`ifdef REG_CMD_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, REJECT, SEND_HDR, SEND_DATA, WAIT_RSP, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic                 wr, rd_phase, err;
    logic [2:0]           rsel;
    logic [REG_WIDTH-1:0] wsh, rsh, rdata, rx_word;
    logic [PW-1:0]        pos;
    logic [RW-1:0]        rcnt;
    logic [TW-1:0]        tcnt;
    logic                 accept, legal, tx_fire, rx_fire, rd_frame, hdr_end, last_beat, rx_full, timeout, data_ok;

    assign accept    = i_cmd_valid && state == IDLE;
    assign legal     = {1'b0, i_cmd_reg} < REG_LIM;
    assign tx_fire   = o_tx_udp_payload_axis_tvalid && i_tx_udp_payload_axis_tready;
    assign rx_fire   = i_rx_udp_payload_axis_tvalid && o_rx_udp_payload_axis_tready;
    assign rd_frame  = !wr || rd_phase;
    assign hdr_end   = pos == PW'(2);
    assign last_beat = rd_frame ? hdr_end : pos == PW'(N + 2);
    assign rx_full   = rcnt == RW'(N - 1);
    assign timeout   = tcnt == TW'(TIMEOUT_CYCLES - 1);
    assign rx_word   = (rsh << 8) | REG_WIDTH'(i_rx_udp_payload_axis_tdata);
    assign data_ok   = !(VERIFY && wr) || rx_word == wsh;

    // State register.
    always_ff @(posedge i_clk)
        state <= i_rst ? IDLE : state_nx;

    // Next-state decode plus the state-derived handshake and response outputs.
    always_comb begin
        state_nx = state;
        o_cmd_ready = state == IDLE;
        o_busy = state != IDLE;
        o_rx_udp_payload_axis_tready = state == WAIT_RSP || state == DRAIN;
        o_rsp_valid = state == DONE;
        o_rsp_error = state == DONE && err;
        o_rsp_rdata = state == DONE ? rdata : '0;
        case (state)
            IDLE:      if (i_cmd_valid) state_nx = legal ? SEND_HDR : REJECT;
            REJECT:    state_nx = DONE;
            SEND_HDR:  if (tx_fire && hdr_end) state_nx = rd_frame ? WAIT_RSP : SEND_DATA;
            SEND_DATA: if (tx_fire && last_beat) state_nx = VERIFY ? SEND_HDR : DONE;
            WAIT_RSP: begin
                if (rx_fire && (i_rx_udp_payload_axis_tlast || rx_full))
                    state_nx = i_rx_udp_payload_axis_tlast ? DONE : DRAIN;
                else if (!rx_fire && timeout)
                    state_nx = DONE;
            end
            DRAIN:     if (rx_fire && i_rx_udp_payload_axis_tlast) state_nx = DONE;
            default:   state_nx = IDLE;
        endcase
    end

    // Frame serialiser, reply assembler and response capture; the write word rotates back to its original value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_tx_udp_payload_axis_tdata  <= '0;
            o_tx_udp_payload_axis_tvalid <= 1'b0;
            o_tx_udp_payload_axis_tlast  <= 1'b0;
            wr       <= 1'b0;
            rd_phase <= 1'b0;
            err      <= 1'b0;
            rsel     <= '0;
            wsh      <= '0;
            rsh      <= '0;
            rdata    <= '0;
            pos      <= '0;
            rcnt     <= '0;
            tcnt     <= '0;
        end else begin
            if (accept) begin
                wr       <= i_cmd_write;
                rsel     <= i_cmd_reg;
                wsh      <= i_cmd_wdata;
                rd_phase <= 1'b0;
                err      <= !legal;
                rdata    <= '0;
                pos      <= '0;
                o_tx_udp_payload_axis_tdata  <= 8'h3A;
                o_tx_udp_payload_axis_tvalid <= legal;
                o_tx_udp_payload_axis_tlast  <= 1'b0;
            end
            if (tx_fire) begin
                if (last_beat) begin
                    o_tx_udp_payload_axis_tvalid <= VERIFY && !rd_frame;
                    o_tx_udp_payload_axis_tdata  <= 8'h3A;
                    o_tx_udp_payload_axis_tlast  <= 1'b0;
                    pos  <= '0;
                    rcnt <= '0;
                    tcnt <= '0;
                    rsh  <= '0;
                    if (!rd_frame) rd_phase <= VERIFY;
                end else begin
                    pos <= pos + 1'b1;
                    o_tx_udp_payload_axis_tdata <= pos == '0 ? 8'h30 + {5'd0, rsel} :
                                                   pos == PW'(1) ? (rd_frame ? 8'h52 : 8'h57) :
                                                   wsh[REG_WIDTH-1 -: 8];
                    o_tx_udp_payload_axis_tlast <= rd_frame ? pos == PW'(1) : pos == PW'(N + 1);
                    if (pos >= PW'(2)) wsh <= (wsh << 8) | (wsh >> (REG_WIDTH - 8));
                end
            end
            if (state == WAIT_RSP) begin
                if (rx_fire) begin
                    rsh  <= rx_word;
                    rcnt <= rcnt + 1'b1;
                    tcnt <= '0;
                    if (i_rx_udp_payload_axis_tlast && rx_full) begin
                        err   <= !data_ok;
                        rdata <= rx_word;
                    end else if (i_rx_udp_payload_axis_tlast || rx_full) begin
                        err   <= 1'b1;
                        rdata <= '0;
                    end
                end else begin
                    tcnt <= tcnt + 1'b1;
                    if (timeout) begin
                        err   <= 1'b1;
                        rdata <= '0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_cmd_initiator.sv
// tb_reg_cmd_initiator: randomized self-checking bench comparing frames and responses with a frame/reply reference model.
`timescale 1ns/1ps
module tb_reg_cmd_initiator;
    localparam int N = 4;
    localparam int TMO = 50;

    logic clk = 1'b0;
    logic rst, cmd_valid, cmd_ready, cmd_write;
    logic [2:0] cmd_reg;
    logic [31:0] cmd_wdata, rsp_rdata;
    logic [7:0] tx_data, rx_data;
    logic tx_valid, tx_last, tx_ready, rx_valid, rx_last, rx_tready, rsp_valid, rsp_error, busy;

    int cyc = 0, checks = 0, errors = 0;
    logic [7:0] reply_q[$], tx_b[$], exp_b[$];
    bit tx_l[$];
    bit rsp_seen, rsp_err_s;
    logic [31:0] rsp_data_s;
    int t_acc, t_rsp, t_last_rx, rx_used, hold_bad;

    reg_cmd_initiator #(.REGS_NUM(4), .REG_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_write(cmd_write),
        .i_cmd_reg(cmd_reg),
        .i_cmd_wdata(cmd_wdata),
        .o_tx_udp_payload_axis_tdata(tx_data),
        .o_tx_udp_payload_axis_tvalid(tx_valid),
        .o_tx_udp_payload_axis_tlast(tx_last),
        .i_tx_udp_payload_axis_tready(tx_ready),
        .i_rx_udp_payload_axis_tdata(rx_data),
        .i_rx_udp_payload_axis_tvalid(rx_valid),
        .i_rx_udp_payload_axis_tlast(rx_last),
        .o_rx_udp_payload_axis_tready(rx_tready),
        .o_rsp_valid(rsp_valid),
        .o_rsp_rdata(rsp_rdata),
        .o_rsp_error(rsp_error),
        .o_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected command frame: ':' , '0'+reg, 'W'/'R', then write data MSB byte first.
    function automatic void build_frame(input bit wr, input logic [2:0] r, input logic [31:0] wd);
        exp_b.delete();
        exp_b.push_back(8'h3A);
        exp_b.push_back(8'h30 + {5'd0, r});
        exp_b.push_back(wr ? 8'h57 : 8'h52);
        if (wr) for (int i = N - 1; i >= 0; i--) exp_b.push_back(wd[8*i +: 8]);
    endfunction

    // Expected read result {error, data}: only a reply of exactly N bytes is good.
    function automatic logic [32:0] exp_read();
        logic [31:0] v;
        v = 0;
        if (reply_q.size() != N) return {1'b1, 32'd0};
        foreach (reply_q[i]) v = {v[23:0], reply_q[i]};
        return {1'b0, v};
    endfunction

    // Issue one request, feed reply_q on RX, collect TX beats and the response.
    task automatic do_txn(input bit wr, input logic [2:0] r, input logic [31:0] wd, input int stall, input bit gaps);
        bit pstall;
        bit pl;
        logic [7:0] pd;
        pstall = 0; pl = 0; pd = 0;
        tx_b.delete(); tx_l.delete();
        rsp_seen = 0; rx_used = 0; hold_bad = 0; t_last_rx = -1; t_rsp = -1;
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_reg = r; cmd_wdata = wd;
        for (int k = 0; k < 20 && !cmd_ready; k++) @(negedge clk);
        t_acc = cyc;
        @(negedge clk);
        cmd_valid = 0;
        for (int k = 0; k < 400 && !rsp_seen; k++) begin
            if (k > 0) @(negedge clk);
            if (rsp_valid) begin
                rsp_seen = 1; t_rsp = cyc; rsp_err_s = rsp_error; rsp_data_s = rsp_rdata;
                rx_valid = 0; rx_last = 0;
            end else begin
                if (pstall && (!tx_valid || tx_data !== pd || tx_last !== pl)) hold_bad++;
                tx_ready = stall == 0 ? 1'b1 : stall == 1 ? (k % 3 == 0) : 1'($urandom_range(0, 1));
                if (tx_valid && tx_ready) begin
                    tx_b.push_back(tx_data);
                    tx_l.push_back(tx_last);
                end
                pstall = tx_valid && !tx_ready; pd = tx_data; pl = tx_last;
                if (rx_used < reply_q.size() && (!gaps || $urandom_range(0, 3) != 0)) begin
                    rx_valid = 1; rx_data = reply_q[rx_used]; rx_last = rx_used == reply_q.size() - 1;
                end else begin
                    rx_valid = 0; rx_last = 0;
                end
                if (rx_valid && rx_tready) begin
                    rx_used++;
                    t_last_rx = cyc;
                end
            end
        end
        tx_ready = 1; rx_valid = 0; rx_last = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
        checks++; if ({tx_valid, tx_last, tx_data} !== 10'd0) begin errors++; $display("FAIL rst_tx got v=%b l=%b d=%h want 0", tx_valid, tx_last, tx_data); end
        checks++; if ({rx_tready, rsp_valid, rsp_error, busy} !== 4'd0) begin errors++; $display("FAIL rst_ctrl got %b want 0000", {rx_tready, rsp_valid, rsp_error, busy}); end
        checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h want 0", rsp_rdata); end
        rst = 0;
        @(negedge clk);
        checks++; if ({cmd_ready, busy} !== 2'b10) begin errors++; $display("FAIL rst_release got ready=%b busy=%b want 1/0", cmd_ready, busy); end
    endtask

    task automatic test_write();
        logic [2:0] r;
        logic [31:0] wd;
        int st;
        for (int it = 0; it < 8; it++) begin
            r  = it < 2 ? 3'd2 : 3'($urandom_range(0, 3));
            wd = it < 2 ? 32'hDEADBEEF : $urandom;
            st = it == 1 ? 1 : it % 3;
            reply_q.delete();
            do_txn(1, r, wd, st, 0);
            build_frame(1, r, wd);
            checks++; if (rsp_seen !== 1'b1) begin errors++; $display("FAIL wr_rsp_seen it=%0d got %b want 1", it, rsp_seen); end
            checks++; if (rsp_err_s !== 1'b0) begin errors++; $display("FAIL wr_error it=%0d got %b want 0", it, rsp_err_s); end
            checks++; if (rsp_data_s !== 32'd0) begin errors++; $display("FAIL wr_rdata it=%0d got %h want 0", it, rsp_data_s); end
            checks++;
            if (tx_b.size() != exp_b.size()) begin
                errors++; $display("FAIL wr_len it=%0d got %0d want %0d", it, tx_b.size(), exp_b.size());
            end else begin
                foreach (exp_b[i]) begin
                    checks++;
                    if (tx_b[i] !== exp_b[i] || tx_l[i] !== (i == exp_b.size() - 1)) begin
                        errors++; $display("FAIL wr_byte it=%0d i=%0d got %h/%b want %h/%b", it, i, tx_b[i], tx_l[i], exp_b[i], i == exp_b.size() - 1);
                    end
                end
            end
            checks++; if (hold_bad != 0) begin errors++; $display("FAIL wr_hold it=%0d got %0d unstable stalls want 0", it, hold_bad); end
            if (st == 0) begin
                checks++; if (t_rsp != t_acc + 4 + N) begin errors++; $display("FAIL wr_latency it=%0d got %0d want %0d", it, t_rsp - t_acc, 4 + N); end
            end
        end
    endtask

    task automatic test_read();
        logic [2:0] r;
        logic [32:0] e;
        int st, len;
        for (int it = 0; it < 10; it++) begin
            r  = it == 0 ? 3'd1 : 3'($urandom_range(0, 3));
            st = it < 3 ? 0 : $urandom_range(0, 2);
            reply_q.delete();
            if (it == 0) reply_q = '{8'hBE, 8'hEF, 8'h12, 8'h34};
            else if (it == 1) reply_q = '{8'hAA, 8'hBB};
            else begin
                len = it == 2 ? 6 : ($urandom_range(0, 1) ? N : $urandom_range(1, 8));
                repeat (len) reply_q.push_back(8'($urandom));
            end
            e = exp_read();
            do_txn(0, r, 32'd0, st, it > 2);
            build_frame(0, r, 32'd0);
            checks++; if (rsp_seen !== 1'b1) begin errors++; $display("FAIL rd_rsp_seen it=%0d got %b want 1", it, rsp_seen); end
            checks++; if (rsp_err_s !== e[32]) begin errors++; $display("FAIL rd_error it=%0d got %b want %b", it, rsp_err_s, e[32]); end
            checks++; if (rsp_data_s !== e[31:0]) begin errors++; $display("FAIL rd_rdata it=%0d got %h want %h", it, rsp_data_s, e[31:0]); end
            checks++;
            if (tx_b.size() != exp_b.size()) begin
                errors++; $display("FAIL rd_len it=%0d got %0d want %0d", it, tx_b.size(), exp_b.size());
            end else begin
                foreach (exp_b[i]) begin
                    checks++;
                    if (tx_b[i] !== exp_b[i] || tx_l[i] !== (i == exp_b.size() - 1)) begin
                        errors++; $display("FAIL rd_byte it=%0d i=%0d got %h/%b want %h/%b", it, i, tx_b[i], tx_l[i], exp_b[i], i == exp_b.size() - 1);
                    end
                end
            end
            checks++; if (rx_used != reply_q.size()) begin errors++; $display("FAIL rd_consumed it=%0d got %0d want %0d", it, rx_used, reply_q.size()); end
            checks++; if (t_rsp != t_last_rx + 1) begin errors++; $display("FAIL rd_latency it=%0d got %0d want %0d", it, t_rsp, t_last_rx + 1); end
            checks++; if (hold_bad != 0) begin errors++; $display("FAIL rd_hold it=%0d got %0d want 0", it, hold_bad); end
            @(negedge clk);
            checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rd_idle it=%0d got %b want 1", it, cmd_ready); end
        end
    endtask

    task automatic test_timeout();
        logic [2:0] r;
        r = 3'($urandom_range(0, 3));
        reply_q.delete();
        do_txn(0, r, 32'd0, 0, 0);
        checks++; if ({rsp_seen, rsp_err_s} !== 2'b11) begin errors++; $display("FAIL tmo_error got seen=%b err=%b want 1/1", rsp_seen, rsp_err_s); end
        checks++; if (rsp_data_s !== 32'd0) begin errors++; $display("FAIL tmo_rdata got %h want 0", rsp_data_s); end
        checks++; if (t_rsp != t_acc + 4 + TMO) begin errors++; $display("FAIL tmo_latency got %0d want %0d", t_rsp - t_acc, 4 + TMO); end
        checks++; if (tx_b.size() != 3) begin errors++; $display("FAIL tmo_len got %0d want 3", tx_b.size()); end
    endtask

    task automatic test_bad_reg();
        for (int r = 4; r < 8; r++) begin
            reply_q.delete();
            do_txn(1'($urandom_range(0, 1)), 3'(r), $urandom, 0, 0);
            checks++; if (tx_b.size() != 0) begin errors++; $display("FAIL bad_tx reg=%0d got %0d beats want 0", r, tx_b.size()); end
            checks++; if ({rsp_seen, rsp_err_s} !== 2'b11) begin errors++; $display("FAIL bad_error reg=%0d got seen=%b err=%b want 1/1", r, rsp_seen, rsp_err_s); end
            checks++; if (rsp_data_s !== 32'd0) begin errors++; $display("FAIL bad_rdata reg=%0d got %h want 0", r, rsp_data_s); end
            checks++; if (t_rsp != t_acc + 2) begin errors++; $display("FAIL bad_latency reg=%0d got %0d want 2", r, t_rsp - t_acc); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] wd;
        int seen, bad;
        bit hit;
        wd = $urandom; seen = 0; bad = 0; hit = 0;
        tx_ready = 1;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_reg = 3'd3; cmd_wdata = wd;
        @(negedge clk);
        cmd_valid = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (k > 0) @(negedge clk);
            if (tx_valid) begin
                if (seen == 4) hit = 1;
                else seen++;
            end
        end
        checks++; if (hit !== 1'b1 || tx_data !== wd[23:16]) begin errors++; $display("FAIL mid_byte got hit=%b data=%h want 1/%h", hit, tx_data, wd[23:16]); end
        rst = 1;
        @(negedge clk);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_tvalid got %b want 0", tx_valid); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", cmd_ready); end
        rst = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid || tx_valid || !cmd_ready) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_quiet got %0d active cycles want 0", bad); end
    endtask

    task automatic test_back_to_back();
        logic [32:0] e;
        logic [31:0] wd;
        for (int it = 0; it < 6; it++) begin
            reply_q.delete();
            if (it % 2 == 0) begin
                wd = $urandom;
                do_txn(1, 3'(it % 4), wd, 0, 0);
                e = 33'd0;
            end else begin
                repeat (it == 3 ? 3 : N) reply_q.push_back(8'($urandom));
                e = exp_read();
                do_txn(0, 3'(it % 4), 32'd0, 0, 0);
            end
            checks++;
            if ({rsp_seen, rsp_err_s, rsp_data_s} !== {1'b1, e}) begin
                errors++; $display("FAIL b2b it=%0d got seen=%b err=%b data=%h want 1/%b/%h", it, rsp_seen, rsp_err_s, rsp_data_s, e[32], e[31:0]);
            end
        end
    endtask

    initial begin
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_reg = 0; cmd_wdata = 0;
        tx_ready = 1; rx_valid = 0; rx_last = 0; rx_data = 0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_bad_reg();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_cmd_initiator.md
Name: reg_cmd_initiator

Overview:
- Host-side counterpart of the UDP register-control responder.
- Accepts register read/write requests on a simple valid/ready command port and serialises them into ASCII command frames on the TX UDP payload AXI-Stream.
- For reads, collects the REG_WIDTH/8-byte reply from the RX UDP payload AXI-Stream and returns the value.
- Instantiated beside the UDP stack wherever the design must drive a remote register bank.

Parameters:
- REGS_NUM, 4: number of addressable remote registers; legal register indices are 0..REGS_NUM-1, REGS_NUM ≤ 8.
- REG_WIDTH, 32: register width in bits; multiple of 8.
- TIMEOUT_CYCLES, 100000: maximum idle clocks in WAIT_RSP before a read is aborted.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_cmd_valid  in  1  request valid
- o_cmd_ready  out  1  request accepted when high together with i_cmd_valid
- i_cmd_write  in  1  1 = write, 0 = read
- i_cmd_reg  in  3  register index
- i_cmd_wdata  in  REG_WIDTH  write data
- o_tx_udp_payload_axis_tdata  out  8  command byte
- o_tx_udp_payload_axis_tvalid  out  1
- o_tx_udp_payload_axis_tlast  out  1
- i_tx_udp_payload_axis_tready  in  1
- i_rx_udp_payload_axis_tdata  in  8  reply byte
- i_rx_udp_payload_axis_tvalid  in  1
- i_rx_udp_payload_axis_tlast  in  1
- o_rx_udp_payload_axis_tready  out  1
- o_rsp_valid  out  1  one-cycle completion pulse
- o_rsp_rdata  out  REG_WIDTH  read data, valid with o_rsp_valid
- o_rsp_error  out  1  error flag, valid with o_rsp_valid
- o_busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Clocking and reset: one clock, i_clk; reset i_rst is synchronous and active-high.
  - Reset values: all outputs 0, except o_cmd_ready, which is 1 in the first cycle after reset.
  - Reset mid-frame: tvalid drops immediately and the partial frame is abandoned without tlast. A pending read is dropped with no o_rsp_valid.
- Frame formats (uppercase only, data sent MSB byte first):
  - Write: ':' (0x3A), 0x30+reg, 'W' (0x57), then REG_WIDTH/8 data bytes; tlast on the last data byte.
  - Read: ':', 0x30+reg, 'R' (0x52); tlast on 'R'.
- TX rules:
  - tdata, tvalid and tlast are registered.
  - While tvalid && !tready, all three are held stable.
  - The byte counter advances only on tvalid && tready.
- States:
  - IDLE:
    - o_cmd_ready=1.
    - On i_cmd_valid: latch write/reg/wdata, o_cmd_ready=0 the next cycle.
    - If i_cmd_reg ≥ REGS_NUM: go to DONE with error=1 and send no frame.
    - Otherwise go to SEND_HDR; the first byte's tvalid is high the cycle after acceptance.
  - SEND_HDR: three header beats.
    - Write: go to SEND_DATA.
    - Read: go to WAIT_RSP after the 'R' beat is accepted.
  - SEND_DATA: REG_WIDTH/8 beats; after the last beat is accepted go to DONE with error=0.
  - WAIT_RSP:
    - o_rx_udp_payload_axis_tready=1; it is 0 in every other state except DRAIN.
    - Each accepted byte is shifted in MSB first.
    - Byte k < N-1 with tlast → DONE, error=1 (short reply).
    - Byte N-1 with tlast → DONE, error=0, rdata = assembled value.
    - Byte N-1 without tlast → DRAIN, error=1 (long reply).
    - Timeout counter clears on entry and on every accepted byte. Reaching TIMEOUT_CYCLES → DONE, error=1, rdata=0.
  - DRAIN: accept and discard bytes up to and including the next tlast, then go to DONE.
  - DONE:
    - o_rsp_valid=1 for exactly one cycle, with rdata and error.
    - Next cycle: IDLE, o_cmd_ready=1.
    - rdata is 0 for writes and for errors.
- Latency, with tready held at 1 and N=REG_WIDTH/8:
  - Write accepted at cycle T: tx beats T+1..T+3+N, o_rsp_valid at T+4+N.
  - Read: rsp_valid the cycle after the last reply byte is accepted.
- RX bytes arriving while tready=0 are not consumed; no overlap of requests is allowed.

Optional Feature:
- Macro: REG_CMD_WRITE_VERIFY_EN.
- Defined:
  - After a write frame completes, the block automatically issues a read frame for the same register.
  - o_rsp_rdata returns the readback value.
  - o_rsp_error=1 if the readback ≠ written data, or on any read error.
  - Only one o_rsp_valid is produced per write request.
- Undefined: writes complete at the end of SEND_DATA as described above; no readback logic is synthesised.

Test Plan:
- Write reg 2, data 0xDEADBEEF, tready=1 → tx bytes 3A 32 57 DE AD BE EF, tlast only on EF; o_rsp_valid at T+8 with error=0.
- Read reg 1, reply BE EF 12 34 with tlast on 34 → tx bytes 3A 31 52, tlast on 52; rsp_valid with rdata=0xBEEF1234, error=0.
- Write with tready toggling 1,0,0,1,... → byte sequence identical to the first case; tdata/tlast held stable during stalls; no byte duplicated or skipped.
- Read with reply AA BB (tlast on BB) → error=1, rdata=0.
- Read with reply of 6 bytes, tlast on byte 6 → error=1; all 6 bytes consumed; block returns to IDLE.
- Read with no reply, TIMEOUT_CYCLES=50 → error=1 exactly 50 cycles after entering WAIT_RSP.
- i_cmd_reg=5 with REGS_NUM=4 → no tx beats; rsp_valid with error=1 two cycles after acceptance.
- i_rst asserted during the 2nd data byte → tvalid=0 the next cycle, o_cmd_ready=1 afterwards, no rsp_valid.
